// File: rtl/instr_fetch.sv
// instr_fetch: PC register, fetch FSM and instruction register with branch/jump redirect, stall and halt
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] InstrAddr,
  input  logic [31:0] Instruction,
  input  logic        stall,
  input  logic        halt,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jump,
  input  logic [25:0] jidx,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  output logic        valid,
  output logic        misalign
);
  typedef enum logic [1:0] {BOOT, RUN, HALTED} state_t;
  state_t state, state_nx;
  logic [31:0] pc, pc_nx, instr_nx, pc_out_nx;
  logic valid_nx, misalign_nx;
  assign InstrAddr = pc;
  assign pc_plus4 = pc_out + 32'd4;
  always_comb begin
    state_nx = state;
    pc_nx = pc;
    instr_nx = instr_out;
    pc_out_nx = pc_out;
    valid_nx = valid;
    misalign_nx = misalign;
    if (state != HALTED) begin
      if (halt) begin
        state_nx = HALTED;
        valid_nx = 1'b0;
      end else if (valid && br_taken) begin
        pc_nx = {br_target[31:2], 2'b00};
        valid_nx = 1'b0;
        misalign_nx = misalign | (|br_target[1:0]);
      end else if (valid && jump) begin
        pc_nx = {pc_plus4[31:28], jidx, 2'b00};
        valid_nx = 1'b0;
      end else if (!stall) begin
        instr_nx = Instruction;
        pc_out_nx = pc;
        valid_nx = 1'b1;
        pc_nx = pc + 32'd4;
        state_nx = RUN;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= BOOT;
      pc <= RESET_PC;
      instr_out <= '0;
      pc_out <= '0;
      valid <= 1'b0;
      misalign <= 1'b0;
    end else begin
      state <= state_nx;
      pc <= pc_nx;
      instr_out <= instr_nx;
      pc_out <= pc_out_nx;
      valid <= valid_nx;
      misalign <= misalign_nx;
    end
  end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed and random checks of instr_fetch against a behavioural fetch model
module tb_instr_fetch;
  logic clk, reset, stall, halt, br_taken, jump;
  logic [31:0] br_target;
  logic [25:0] jidx;
  logic [31:0] addr, instr, instr_out, pc_out, pc_plus4;
  logic valid, misalign;
  logic [31:0] addr2, instr2, instr_out2, pc_out2, pc_plus42;
  logic valid2, misalign2;
  int total = 0;
  int bad = 0;
  logic [31:0] m_pc, m_instr, m_pcout, saved;
  logic m_valid, m_mis, m_halted;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    case (a)
      32'h0:  return 32'h2004000a;
      32'h10: return 32'h11040003;
      32'h14: return 32'h01284820;
      default: return (a * 32'h9E3779B1) ^ 32'hC3A55A3C;
    endcase
  endfunction

  assign instr = mem_f(addr);
  assign instr2 = mem_f(addr2);

  instr_fetch dut (
    .clk(clk), .reset(reset), .InstrAddr(addr), .Instruction(instr), .stall(stall), .halt(halt),
    .br_taken(br_taken), .br_target(br_target), .jump(jump), .jidx(jidx), .instr_out(instr_out),
    .pc_out(pc_out), .pc_plus4(pc_plus4), .valid(valid), .misalign(misalign)
  );

  instr_fetch #(.RESET_PC(32'hFFFFFFFC)) dut2 (
    .clk(clk), .reset(reset), .InstrAddr(addr2), .Instruction(instr2), .stall(stall), .halt(halt),
    .br_taken(br_taken), .br_target(br_target), .jump(jump), .jidx(jidx), .instr_out(instr_out2),
    .pc_out(pc_out2), .pc_plus4(pc_plus42), .valid(valid2), .misalign(misalign2)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic [31:0] nxt;
    if (reset) begin
      m_pc = 32'h0; m_instr = 0; m_pcout = 0; m_valid = 0; m_mis = 0; m_halted = 0;
    end else if (!m_halted) begin
      if (halt) begin
        m_halted = 1; m_valid = 0;
      end else if (m_valid && br_taken) begin
        m_pc = br_target & ~32'd3; m_valid = 0;
        if (br_target % 4 != 0) m_mis = 1;
      end else if (m_valid && jump) begin
        nxt = m_pcout + 4;
        m_pc = (nxt & 32'hF0000000) + 32'(jidx) * 4; m_valid = 0;
      end else if (!stall) begin
        m_instr = mem_f(m_pc); m_pcout = m_pc; m_valid = 1; m_pc = m_pc + 4;
      end
    end
  endtask

  task automatic check_all();
    chk("InstrAddr", addr, m_pc);
    chk("instr_out", instr_out, m_instr);
    chk("pc_out", pc_out, m_pcout);
    chk("pc_plus4", pc_plus4, m_pcout + 32'd4);
    chk("valid", 32'(valid), 32'(m_valid));
    chk("misalign", 32'(misalign), 32'(m_mis));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle();
    stall = 0; halt = 0; br_taken = 0; jump = 0;
  endtask

  initial begin
    reset = 1; idle(); br_target = 0; jidx = 0;
    tick(); tick();
    chk("rst_addr", addr, 32'h0);
    chk("rst_pc4", pc_plus4, 32'h4);
    chk("rst_addr2", addr2, 32'hFFFFFFFC);
    chk("rst_valid2", 32'(valid2), 32'h0);
    reset = 0;
    tick();
    chk("boot_instr", instr_out, 32'h2004000a);
    chk("boot_pc", pc_out, 32'h0);
    chk("boot_valid", 32'(valid), 32'h1);
    chk("boot_addr", addr, 32'h4);
    chk("wrap_pc", pc_out2, 32'hFFFFFFFC);
    chk("wrap_pc4", pc_plus42, 32'h0);
    chk("wrap_addr", addr2, 32'h0);
    chk("wrap_instr", instr_out2, mem_f(32'hFFFFFFFC));
    repeat (4) tick();
    chk("run5_pc", pc_out, 32'h10);
    chk("run5_instr", instr_out, 32'h11040003);
    tick();
    chk("run6_pc", pc_out, 32'h14);
    chk("run6_instr", instr_out, 32'h01284820);
    br_taken = 1; br_target = 32'h10;
    tick();
    chk("br_valid", 32'(valid), 32'h0);
    chk("br_addr", addr, 32'h10);
    idle();
    tick();
    chk("br_instr", instr_out, 32'h11040003);
    chk("br_valid1", 32'(valid), 32'h1);
    reset = 1;
    tick();
    reset = 0;
    tick();
    jump = 1; jidx = 26'h5;
    tick();
    chk("j_addr", addr, 32'h14);
    chk("j_valid", 32'(valid), 32'h0);
    idle();
    tick();
    br_taken = 1; jump = 1; br_target = 32'h40; jidx = 26'h5;
    tick();
    chk("brj_addr", addr, 32'h40);
    idle();
    tick();
    stall = 1;
    repeat (3) begin
      tick();
      chk("st_addr", addr, 32'h44);
      chk("st_pc", pc_out, 32'h40);
      chk("st_instr", instr_out, mem_f(32'h40));
    end
    br_taken = 1; br_target = 32'h80;
    tick();
    chk("st_br_addr", addr, 32'h80);
    idle();
    tick();
    br_taken = 1; br_target = 32'h13;
    tick();
    chk("mis_flag", 32'(misalign), 32'h1);
    chk("mis_addr", addr, 32'h10);
    idle();
    repeat (400) begin
      stall = ($urandom_range(0, 3) == 0);
      br_taken = ($urandom_range(0, 9) == 0);
      jump = ($urandom_range(0, 9) == 0);
      br_target = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFC);
      jidx = 26'($urandom);
      tick();
    end
    idle();
    tick();
    halt = 1;
    tick();
    chk("halt_valid", 32'(valid), 32'h0);
    saved = m_pc;
    repeat (10) begin
      halt = 1'($urandom); stall = 1'($urandom); br_taken = 1'($urandom); jump = 1'($urandom);
      br_target = $urandom; jidx = 26'($urandom);
      tick();
      chk("halt_addr", addr, saved);
      chk("halt_valid_hold", 32'(valid), 32'h0);
    end
    reset = 1;
    tick();
    chk("hrst_addr", addr, 32'h0);
    chk("hrst_mis", 32'(misalign), 32'h0);
    reset = 0; idle();
    tick();
    chk("hrst_run", 32'(valid), 32'h1);
    chk("hrst_instr", instr_out, 32'h2004000a);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h00000000, giving the first fetch address after reset.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, reset that is synchronous and active-high.
REQ-004 The block SHALL have port InstrAddr, output, 32, the fetch address driven to the instruction port of memory.
REQ-005 The block SHALL have port Instruction, input, 32, the combinational read data returned by memory for InstrAddr.
REQ-006 The block SHALL have port stall, input, 1, which holds the PC and the instruction register.
REQ-007 The block SHALL have port halt, input, 1, a request to stop fetching until reset.
REQ-008 The block SHALL have port br_taken, input, 1, which redirects fetch to br_target.
REQ-009 The block SHALL have port br_target, input, 32, the branch destination address.
REQ-010 The block SHALL have port jump, input, 1, which redirects fetch to the J-type target.
REQ-011 The block SHALL have port jidx, input, 26, the J-type instruction index.
REQ-012 The block SHALL have port instr_out, output, 32, the registered instruction.
REQ-013 The block SHALL have port pc_out, output, 32, the address instr_out was fetched from.
REQ-014 The block SHALL have port pc_plus4, output, 32, equal to pc_out+4 modulo 2^32.
REQ-015 The block SHALL have port valid, output, 1, high when instr_out holds a live instruction.
REQ-016 The block SHALL have port misalign, output, 1, a sticky flag for a redirect target with nonzero bits [1:0].

Function
REQ-017 The block SHALL hold the PC in a 32-bit register and drive InstrAddr = PC combinationally, without a register stage.
REQ-018 The FSM SHALL have states BOOT, RUN and HALTED.
REQ-019 The FSM SHALL enter BOOT on reset; the first edge out of reset SHALL latch the instruction at RESET_PC and move to RUN.
REQ-020 In BOOT or RUN with stall=0 and no redirect, each edge SHALL load instr_out<=Instruction, pc_out<=PC, valid<=1 and PC<=PC+4.
REQ-021 PC+4 SHALL wrap modulo 2^32, so 32'hFFFFFFFC advances to 32'h00000000 with no flag.
REQ-022 Redirect priority SHALL be reset > halt > br_taken > jump > stall > sequential.
REQ-023 With br_taken=1 in RUN, the next edge SHALL set PC<={br_target[31:2],2'b00} and valid<=0, flushing the wrong-path instruction, regardless of stall.
REQ-024 With jump=1 and br_taken=0 in RUN, the next edge SHALL set PC<={pc_plus4[31:28],jidx,2'b00} and valid<=0.
REQ-025 A redirect SHALL be honoured only while valid=1; br_taken and jump SHALL be ignored when valid=0.
REQ-026 misalign SHALL be set on the edge of an honoured br_taken whose br_target[1:0]!=0, and SHALL clear only on reset.
REQ-027 With stall=1 and no redirect, PC, instr_out, pc_out and valid SHALL hold their values.
REQ-028 With halt=1 in RUN, the next edge SHALL go to HALTED with valid<=0 and PC held.
REQ-029 HALTED SHALL ignore every input except reset, with InstrAddr constant.

Reset
REQ-030 While reset=1 at an edge, the block SHALL set PC<=RESET_PC, instr_out<=0, pc_out<=0, valid<=0, misalign<=0 and state<=BOOT.
REQ-031 pc_plus4 SHALL read 32'h00000004 in reset, following from pc_out=0.
REQ-032 Reset asserted mid-stall, mid-redirect or in HALTED SHALL take effect on that edge and override all other inputs.

Verification
REQ-033 Memory preloaded with 0x2004000a at 0x0; reset, then release -> InstrAddr=0x0 during reset; after 1st edge instr_out=0x2004000a, pc_out=0x0, valid=1, InstrAddr=0x4.
REQ-034 Free-run 5 edges from reset with memory 0x11040003 at 0x10 -> pc_out=0x10, instr_out=0x11040003; 1 more edge -> instr_out=0x01284820, pc_out=0x14.
REQ-035 br_taken=1 with br_target=0x10 while valid=1 -> next edge valid=0, InstrAddr=0x10; following edge instr_out=0x11040003, valid=1.
REQ-036 jump=1 with jidx=26'h0000005, pc_out=0x0 -> next edge InstrAddr=0x14 and valid=0; br_taken+jump together -> br_target wins.
REQ-037 stall=1 for 3 edges -> pc_out, instr_out and InstrAddr are unchanged; br_taken during stall still redirects.
REQ-038 RESET_PC=0xFFFFFFFC -> after 1st edge pc_out=0xFFFFFFFC, pc_plus4=0x0, InstrAddr=0x0.
REQ-039 br_target=0x13 -> misalign=1, InstrAddr=0x10, and misalign holds until reset.
REQ-040 halt=1 -> HALTED, valid=0 and InstrAddr frozen for 10 edges; reset -> BOOT.
